// File: rtl/reg_file_32x32_pkg.sv
// rtl/reg_file_32x32_pkg.sv - shared register-file widths, constants and types
package reg_file_32x32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Shared with the rt/rd destination select and the write-back stage
  typedef logic [REG_ADDR_W-1:0] regAddr_t;
  typedef logic [REG_DATA_W-1:0] regData_t;

endpackage

// File: rtl/reg_file_32x32_write_addr_decoder.sv
// rtl/reg_file_32x32_write_addr_decoder.sv - write address to one-hot register enable, bit 0 never set
module write_addr_decoder #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                wrEn,
  input  logic [ADDR_W-1:0]   wrAddr,
  output logic [NUM_REGS-1:0] reg_en
);
  import reg_file_32x32_pkg::*;

  // Gating on wrEn first keeps an undriven address from reaching any enable
  always_comb begin
    reg_en = '0;
    if (wrEn && (wrAddr != ADDR_W'(REG_ZERO))) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wrAddr == ADDR_W'(i)) begin
          reg_en[i] = 1'b1;
        end
      end
    end
    reg_en[0] = 1'b0;
  end

endmodule

// File: rtl/reg_file_32x32.sv
// rtl/reg_file_32x32.sv - 32x32 register file, 1 sync write / 2 comb reads; RF_BYPASS_EN adds write-through
module reg_file_32x32 #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [DATA_W-1:0] rdDataA,
  output logic [DATA_W-1:0] rdDataB
);
  import reg_file_32x32_pkg::*;

  logic [NUM_REGS-1:0] reg_en;
  // Register 0 has no storage; the array starts at 1
  logic [DATA_W-1:0]   regs [1:NUM_REGS-1];

  write_addr_decoder #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_write_addr_decoder (
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .reg_en (reg_en)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (reg_en[i]) begin
          regs[i] <= wrData;
        end
      end
    end
  end

  always_comb begin
    rdDataA = '0;
    rdDataB = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rdAddrA == ADDR_W'(i)) rdDataA = regs[i];
      if (rdAddrB == ADDR_W'(i)) rdDataB = regs[i];
    end
`ifdef RF_BYPASS_EN
    // Write-back/decode overlap: same-cycle reader sees the data being written
    if (!rstN) begin
      rdDataA = '0;
      rdDataB = '0;
    end else if (wrEn && (wrAddr != ADDR_W'(REG_ZERO))) begin
      if (rdAddrA == wrAddr) rdDataA = wrData;
      if (rdAddrB == wrAddr) rdDataB = wrData;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_32x32.sv
// tb/tb_reg_file_32x32.sv - directed self-checking bench for reg_file_32x32
module tb_reg_file_32x32;

  logic        clk = 1'b0;
  logic        rstN;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [4:0]  rdAddrA;
  logic [4:0]  rdAddrB;
  logic [31:0] rdDataA;
  logic [31:0] rdDataB;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_32x32 dut (
    .clk     (clk),
    .rstN    (rstN),
    .wrEn    (wrEn),
    .wrAddr  (wrAddr),
    .wrData  (wrData),
    .rdAddrA (rdAddrA),
    .rdAddrB (rdAddrB),
    .rdDataA (rdDataA),
    .rdDataB (rdDataB)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic read_pair(input logic [4:0] a, input logic [4:0] b);
    rdAddrA = a;
    rdAddrB = b;
    #1;
  endtask

  task automatic write_edge(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    wrEn   = 1'b1;
    wrAddr = addr;
    wrData = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    @(negedge clk);
    wrEn = 1'b0;
    #1;
  endtask

  logic [31:0] exp_same;

  initial begin
    rstN = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0; rdAddrA = '0; rdAddrB = '0;

    // Reset with pending write, then all addresses read 0
    wrEn = 1'b1; wrAddr = 5'd4; wrData = 32'h5555_AAAA;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rstN = 1'b1; wrEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_pair(5'(i), 5'(31 - i));
      check($sformatf("rst_a%0d", i), rdDataA, 32'h0);
      check($sformatf("rst_b%0d", 31 - i), rdDataB, 32'h0);
    end

    // Basic write
    write_edge(5'd8, 32'hDEAD_BEEF);
    idle();
    read_pair(5'd8, 5'd9);
    check("basic_r8", rdDataA, 32'hDEAD_BEEF);
    check("basic_r9", rdDataB, 32'h0);

    // Register 0 write discarded, same-cycle and after
    @(negedge clk);
    wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'hFFFF_FFFF;
    read_pair(5'd0, 5'd0);
    check("r0_same_a", rdDataA, 32'h0);
    check("r0_same_b", rdDataB, 32'h0);
    @(posedge clk); #1;
    idle();
    read_pair(5'd0, 5'd0);
    check("r0_after_a", rdDataA, 32'h0);
    check("r0_after_b", rdDataB, 32'h0);

    // Dual read during same-cycle write
    write_edge(5'd3, 32'h1111_1111);
    @(negedge clk);
    wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'h2222_2222;
    read_pair(5'd3, 5'd3);
`ifdef RF_BYPASS_EN
    exp_same = 32'h2222_2222;
`else
    exp_same = 32'h1111_1111;
`endif
    check("dual_same_a", rdDataA, exp_same);
    check("dual_same_b", rdDataB, exp_same);
    @(posedge clk); #1;
    idle();
    read_pair(5'd3, 5'd3);
    check("dual_after_a", rdDataA, 32'h2222_2222);
    check("dual_after_b", rdDataB, 32'h2222_2222);

    // Back-to-back writes to the same address: last wins
    write_edge(5'd7, 32'hAAAA_0001);
    write_edge(5'd7, 32'hBBBB_0002);
    idle();
    read_pair(5'd7, 5'd8);
    check("b2b_r7", rdDataA, 32'hBBBB_0002);
    check("b2b_r8", rdDataB, 32'hDEAD_BEEF);

    // wrEn low with address/data toggling must not write
    @(negedge clk);
    wrEn = 1'b0; wrAddr = 5'd8; wrData = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    read_pair(5'd8, 5'd7);
    check("noen_r8", rdDataA, 32'hDEAD_BEEF);
    check("noen_r7", rdDataB, 32'hBBBB_0002);

    // Reset priority over concurrent write, clears all
    write_edge(5'd31, 32'h1234_5678);
    @(negedge clk);
    rstN = 1'b0; wrEn = 1'b1; wrAddr = 5'd31; wrData = 32'hCAFE_F00D;
    read_pair(5'd31, 5'd8);
`ifdef RF_BYPASS_EN
    check("inrst_r31", rdDataA, 32'h0);
    check("inrst_r8", rdDataB, 32'h0);
`else
    check("inrst_r31", rdDataA, 32'h1234_5678);
    check("inrst_r8", rdDataB, 32'hDEAD_BEEF);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    rstN = 1'b1; wrEn = 1'b0;
    read_pair(5'd31, 5'd8);
    check("rstpri_r31", rdDataA, 32'h0);
    check("rstpri_r8", rdDataB, 32'h0);
    read_pair(5'd3, 5'd7);
    check("rstclr_r3", rdDataA, 32'h0);
    check("rstclr_r7", rdDataB, 32'h0);

    // First edge with rstN=1 accepts a write
    @(negedge clk);
    rstN = 1'b0; wrEn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1; wrEn = 1'b1; wrAddr = 5'd12; wrData = 32'hABCD_0012;
    @(posedge clk); #1;
    idle();
    read_pair(5'd12, 5'd13);
    check("firstwr_r12", rdDataA, 32'hABCD_0012);
    check("firstwr_r13", rdDataB, 32'h0);

    // Walking writes on consecutive edges
    for (int i = 1; i < 32; i++) begin
      write_edge(5'(i), 32'h100 + 32'(i));
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      read_pair(5'(i), 5'(31 - i));
      check($sformatf("walk_a%0d", i), rdDataA, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
      check($sformatf("walk_b%0d", 31 - i), rdDataB, (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_32x32.md
# reg_file_32x32

Register file for the datapath: 32 registers of 32 bits, with one synchronous write port and two combinational read ports. It is the receiving end of the 5-bit destination-register select, which chooses between instruction fields rt and rd. The block decodes that 5-bit write address into a one-hot register enable and commits write-back data on the clock edge. Register 0 reads as constant zero.

## Interface
- DATA_W, default 32: register and data width in bits.
- ADDR_W, default 5: register address width in bits.
- NUM_REGS, default 32: number of registers; must equal 2**ADDR_W.
- clk  input  1  rising-edge clock for all state.
- rstN  input  1  reset; synchronous, active-low.
- wrEn  input  1  write enable, sampled on rising clk.
- wrAddr  input  ADDR_W  destination register (output of the rt/rd select).
- wrData  input  DATA_W  write-back data.
- rdAddrA  input  ADDR_W  read port A address (rs).
- rdAddrB  input  ADDR_W  read port B address (rt).
- rdDataA  output  DATA_W  read port A data, combinational from rdAddrA.
- rdDataB  output  DATA_W  read port B data, combinational from rdAddrB.

## Operation
- State: regs[1..31], each DATA_W wide. regs[0] is not stored; it always reads 0.
- Write decode: when wrEn=1, the decoder produces a one-hot enable with bit wrAddr set. Bit 0 is always forced to 0, so writes to register 0 are silently discarded.
- Commit: on rising clk with rstN=1 and wrEn=1, regs[wrAddr] <= wrData. All other registers hold their values.
- Reset: on rising clk with rstN=0, all regs[1..31] <= 0.
  - Reset has priority over any concurrent write; that write is lost.
  - Reset asserted mid-program clears everything in one cycle. The first write accepted after reset is on the first edge with rstN=1.
- Read: rdDataX = (rdAddrX == 0) ? 0 : regs[rdAddrX]. Reads are purely combinational, with no clock dependency.
- Both read ports may address the same register, or the write address, in the same cycle; there is no conflict or stall.
- There is no handshake. A write is always accepted in one cycle.

## Timing
- Write latency: data presented in cycle N is visible on the read ports from cycle N+1, after the edge. The exception is when bypass is enabled (see Configuration).
- Read latency: 0 cycles, combinational from the address and register state.
- Output reset values: rdDataA = rdDataB = 0 for any address after a reset edge, until a write occurs.
- Back-to-back writes to the same address on consecutive edges: the last write wins, with one value committed per edge.
- X on wrAddr while wrEn=0 must not corrupt state.

## Configuration
- Macro: RF_BYPASS_EN.
- Defined: write-through bypass. If wrEn=1, wrAddr!=0, rstN=1 and rdAddrX==wrAddr, then rdDataX = wrData in the same cycle. This serves the write-back/decode overlap in the pipelined datapath.
- Defined, during reset: the bypass is suppressed while rstN=0, and reads return 0.
- Not defined: reads return the stored value only. Same-cycle readers see the old value until the next cycle.

## Structure
- The shared package holds:
  - REG_ADDR_W = 5, REG_DATA_W = 32, NUM_REGS = 32;
  - REG_ZERO = 5'd0;
  - typedefs regAddr_t (5-bit) and regData_t (32-bit), also used by the rt/rd select and the write-back stage.
- Sub-module write_addr_decoder: inputs wrEn and wrAddr, output a NUM_REGS-bit one-hot enable with bit 0 forced low.
  - Purely combinational.
  - Instantiated once by reg_file_32x32.
- The register array and the read muxing stay in the top module.

## Test plan
- Reset: hold rstN=0 for 2 edges, then read all 32 addresses on both ports -> every read returns 0x00000000.
- Basic write: wrEn=1, wrAddr=5'd8, wrData=0xDEADBEEF for one edge, then rdAddrA=8 -> rdDataA=0xDEADBEEF. Register 9 stays 0.
- Register 0: write 0xFFFFFFFF to address 0 -> rdDataA and rdDataB at address 0 both return 0. Under RF_BYPASS_EN, the same-cycle read of address 0 also returns 0.
- Dual read plus same-cycle write: regs[3]=0x11111111, then write 0x22222222 to address 3 with rdAddrA=rdAddrB=3.
  - Without the macro: 0x11111111 during the write cycle, 0x22222222 after.
  - With RF_BYPASS_EN: 0x22222222 in both cycles.
- Reset priority: with rstN=0 and wrEn=1, write 0xCAFEF00D to address 31 -> after the edge, rdDataA at address 31 = 0.
- Walking writes: write value 0x100+i to address i for i=1..31 on consecutive edges, then read all addresses -> each returns 0x100+i, and address 0 returns 0.
